// File: rtl/cxor_sched.sv
// Two-requester round-robin scheduler driving an iterated conditional XOR/AND unit.
// Each pass computes acc = acc[7] ? (acc & b) : (acc ^ b); the result is returned tagged with the requester ID.
//
// state | meaning
// IDLE  | waiting for a job, arbitrating between requesters
// RUN   | applying one conditional pass per cycle
// DONE  | holding the result until the consumer takes it
module cxor_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_iter,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_iter,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_id,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] bop_q, bop_d;
    logic [2:0] cnt_q, cnt_d;
    logic       id_q, id_d;
    logic       last_q, last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 8'h00;
            bop_q   <= 8'h00;
            cnt_q   <= 3'd0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bop_q   <= bop_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        bop_d   = bop_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    acc_d   = req0_a;
                    bop_d   = req0_b;
                    cnt_d   = req0_iter;
                    id_d    = 1'b0;
                    last_d  = 1'b0;
                    state_d = RUN;
                end else if (req1_ready) begin
                    acc_d   = req1_a;
                    bop_d   = req1_b;
                    cnt_d   = req1_iter;
                    id_d    = 1'b1;
                    last_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // mode is chosen from the current accumulator MSB on every pass
                acc_d = acc_q[7] ? (acc_q & bop_q) : (acc_q ^ bop_q);
                if (cnt_q == 3'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // on a tie the requester that did not win last time gets the grant
        if (state_q == IDLE && !rst) begin
            if (req0_valid && (!req1_valid || last_q)) req0_ready = 1'b1;
            else if (req1_valid)                       req1_ready = 1'b1;
        end
        res_valid = (state_q == DONE);
        res_data  = acc_q;
        res_id    = id_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_cxor_sched.sv
// Self-checking bench for cxor_sched: vector table, directed corner sequences,
// and a randomized run against a scoreboard model of arbitration and results.
module tb_cxor_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic [2:0] req0_iter = 3'd0, req1_iter = 3'd0;
    logic       res_valid, res_id, busy;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    cxor_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_iter(req0_iter),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_iter(req1_iter),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    typedef struct {
        logic       r;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] it;
        logic [7:0] ed;
        logic       eid;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] it);
        logic [7:0] acc;
        acc = a;
        for (int i = 0; i <= int'(it); i++)
            acc = acc[7] ? (acc & b) : (acc ^ b);
        return acc;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // one job with res_ready already high; returns result, latency and busy-cycle count
    task automatic do_job(input logic r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] it,
                          output logic [7:0] d, output logic id, output int lat, output int bsy);
        int k;
        d = 8'h00; id = 1'b0; lat = 0; bsy = 0; k = 0;
        @(negedge clk);
        if (r) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_iter = it; end
        else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_iter = it; end
        #1;
        while (!(r ? req1_ready : req0_ready) && k < 20) begin
            @(negedge clk); #1; k++;
        end
        if (k >= 20) begin
            chk("grant_timeout", 0, 1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (busy) bsy++;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (busy) bsy++;
        end
        d = res_data;
        id = res_id;
        @(posedge clk); #1;
        if (busy) bsy++;
    endtask

    logic [7:0] d;
    logic       id;
    int         lat, bsy, k;
    int         gq[$];
    int         rq[$];
    logic [7:0] q_d[$];
    logic       q_id[$];
    int         last_w;
    logic       m_idle;
    logic       e0, e1;

    initial begin
        vecs[0] = '{1'b0, 8'h35, 8'h0F, 3'd0, 8'h3A, 1'b0};
        vecs[1] = '{1'b1, 8'h8F, 8'hF3, 3'd0, 8'h83, 1'b1};
        vecs[2] = '{1'b0, 8'h7F, 8'h81, 3'd2, 8'h80, 1'b0};
        vecs[3] = '{1'b1, 8'h00, 8'hFF, 3'd7, 8'hFF, 1'b1};
        vecs[4] = '{1'b0, 8'h80, 8'h00, 3'd3, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 8'h12, 8'h34, 3'd1, 8'h12, 1'b1};

        // reset values while rst is high, with both requesters asking
        req0_valid = 1'b1; req1_valid = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        do_reset();

        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_job(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].it, d, id, lat, bsy);
            chk($sformatf("vec%0d_data", i), d, vecs[i].ed);
            chk($sformatf("vec%0d_id", i), id, vecs[i].eid);
            chk($sformatf("vec%0d_latency", i), lat, int'(vecs[i].it) + 1);
            chk($sformatf("vec%0d_busy_cycles", i), bsy, int'(vecs[i].it) + 2);
        end

        // round-robin with both requesters permanently valid
        do_reset();
        res_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h35; req0_b = 8'h0F; req0_iter = 3'd0;
        req1_valid = 1'b1; req1_a = 8'h8F; req1_b = 8'hF3; req1_iter = 3'd0;
        repeat (16) begin
            #1;
            chk("rr_both_ready", int'(req0_ready && req1_ready), 0);
            if (req0_ready) gq.push_back(0);
            if (req1_ready) gq.push_back(1);
            if (res_valid && res_ready) rq.push_back(int'(res_id));
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), (i < gq.size()) ? gq[i] : 9, i % 2);
            chk($sformatf("rr_res_id%0d", i), (i < rq.size()) ? rq[i] : 9, i % 2);
        end

        // backpressure: result held while req1 keeps asking
        do_reset();
        res_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_iter = 3'd1;
        #1;
        k = 0;
        while (!req0_ready && k < 20) begin @(negedge clk); #1; k++; end
        chk("bp_grant0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h00; req1_iter = 3'd5;
        k = 0;
        while (!res_valid && k < 20) begin @(posedge clk); #1; k++; end
        repeat (5) begin
            @(negedge clk); #1;
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_data", res_data, 8'h12);
            chk("bp_res_id", res_id, 0);
            chk("bp_ready1", req1_ready, 0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        req1_a = 8'h8F; req1_b = 8'hF3; req1_iter = 3'd0;
        #1;
        chk("bp_ready1_at_handshake", req1_ready, 0);
        @(posedge clk); #1;
        chk("bp_after_hs_valid", res_valid, 0);
        chk("bp_after_hs_busy", busy, 0);
        chk("bp_after_hs_ready1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        chk("bp_req1_accepted", busy, 1);
        k = 0;
        while (!res_valid && k < 20) begin @(posedge clk); #1; k++; end
        chk("bp_req1_data", res_data, 8'h83);
        chk("bp_req1_id", res_id, 1);
        @(posedge clk); #1;

        // reset in the third RUN cycle of a long job
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h35; req0_b = 8'h0F; req0_iter = 3'd7;
        #1;
        k = 0;
        while (!req0_ready && k < 20) begin @(negedge clk); #1; k++; end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_data", res_data, 0);
        chk("mid_rst_res_id", res_id, 0);
        chk("mid_rst_ready0", req0_ready, 0);
        chk("mid_rst_ready1", req1_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);

        // randomized traffic against the scoreboard
        do_reset();
        last_w = 1;
        m_idle = 1'b1;
        repeat (400) begin
            @(negedge clk);
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_iter = 3'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_iter = 3'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            e0 = 1'b0; e1 = 1'b0;
            if (m_idle) begin
                if (req0_valid && req1_valid) begin
                    e0 = (last_w == 1);
                    e1 = (last_w == 0);
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end
            chk("rnd_ready0", req0_ready, e0);
            chk("rnd_ready1", req1_ready, e1);
            if (e0) begin
                q_d.push_back(model(req0_a, req0_b, req0_iter)); q_id.push_back(1'b0);
                last_w = 0; m_idle = 1'b0;
            end else if (e1) begin
                q_d.push_back(model(req1_a, req1_b, req1_iter)); q_id.push_back(1'b1);
                last_w = 1; m_idle = 1'b0;
            end
            if (res_valid && res_ready) begin
                if (q_d.size() == 0) chk("rnd_unexpected_result", 1, 0);
                else begin
                    chk("rnd_res_data", res_data, q_d.pop_front());
                    chk("rnd_res_id", res_id, q_id.pop_front());
                end
                m_idle = 1'b1;
            end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
            if (res_valid && res_ready && q_d.size() != 0) begin
                chk("drain_res_data", res_data, q_d.pop_front());
                chk("drain_res_id", res_id, q_id.pop_front());
            end
        end
        chk("drain_outstanding", q_d.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
